// File: rtl/bcd_display_driver.sv
// bcd_display_driver
// Converts an 8-bit binary count (0..255) to three BCD digits using a serial
// shift-and-add-3 engine (one bit per clock). It also drives three active-low
// 7-segment displays from the committed digits.
//
// Ports
//   clk_i           system clock, rising edge
//   rst_ni          asynchronous active-low reset
//   value_i[7:0]    binary value to convert
//   load_i          conversion request, sampled on the rising edge
//   blank_zeros_i   blank leading-zero digits on hex2_o / hex1_o
//   busy_o          conversion in progress
//   done_o          one-cycle pulse when new digits are committed
//   valid_o         at least one conversion completed since reset
//   ones_o, tens_o, hundreds_o [3:0]  committed BCD digits
//   hex0_o, hex1_o, hex2_o [7:0]      active-low {dp, g..a} for ones/tens/hundreds
module bcd_display_driver (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] value_i,
    input  logic       load_i,
    input  logic       blank_zeros_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       valid_o,
    output logic [3:0] ones_o,
    output logic [3:0] tens_o,
    output logic [3:0] hundreds_o,
    output logic [7:0] hex0_o,
    output logic [7:0] hex1_o,
    output logic [7:0] hex2_o
);

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [11:0] scratch_q, scratch_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        pend_q, pend_d;
    logic [7:0]  pbuf_q, pbuf_d;
    logic [3:0]  ones_q, ones_d;
    logic [3:0]  tens_q, tens_d;
    logic [3:0]  hund_q, hund_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        valid_q, valid_d;

    logic [11:0] adj_s;
    logic [11:0] scratch_step_s;
    logic [7:0]  shift_step_s;

    // Add 3 to a BCD digit of 5 or more, so that the following doubling carries correctly.
    function automatic logic [3:0] dabble_adj(input logic [3:0] d);
        if (d >= 4'd5) begin
            return d + 4'd3;
        end else begin
            return d;
        end
    endfunction

    // Active-low segment pattern g..a for one digit; non-decimal codes show a dash.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0011000;
            default: return 7'b0111111;
        endcase
    endfunction

    // One conversion step: adjust each scratch digit, then shift {scratch, shift} left.
    always_comb begin
        adj_s          = {dabble_adj(scratch_q[11:8]), dabble_adj(scratch_q[7:4]),
                          dabble_adj(scratch_q[3:0])};
        // The hundreds digit never exceeds 2 before the last shift, so the
        // bit pushed out of the top is always zero.
        scratch_step_s = (adj_s << 1) | {11'd0, shift_q[7]};
        shift_step_s   = {shift_q[6:0], 1'b0};
    end

    // Next-state and datapath control.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        pbuf_d    = pbuf_q;
        ones_d    = ones_q;
        tens_d    = tens_q;
        hund_d    = hund_q;
        done_d    = 1'b0;
        valid_d   = valid_q;

        case (state_q)
            IDLE: begin
                if (pend_q) begin
                    // Buffered request wins; a new load here becomes the next pending one.
                    state_d   = CONV;
                    shift_d   = pbuf_q;
                    scratch_d = 12'd0;
                    cnt_d     = 4'd8;
                    pend_d    = load_i;
                    if (load_i) begin
                        pbuf_d = value_i;
                    end else begin
                        pbuf_d = pbuf_q;
                    end
                end else if (load_i) begin
                    state_d   = CONV;
                    shift_d   = value_i;
                    scratch_d = 12'd0;
                    cnt_d     = 4'd8;
                end else begin
                    state_d = IDLE;
                end
            end
            CONV: begin
                scratch_d = scratch_step_s;
                shift_d   = shift_step_s;
                cnt_d     = cnt_q - 4'd1;
                if (load_i) begin
                    pend_d = 1'b1;
                    pbuf_d = value_i;
                end else begin
                    pend_d = pend_q;
                end
                if (cnt_q == 4'd1) begin
                    hund_d  = scratch_step_s[11:8];
                    tens_d  = scratch_step_s[7:4];
                    ones_d  = scratch_step_s[3:0];
                    done_d  = 1'b1;
                    valid_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = CONV;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == CONV);
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            shift_q   <= 8'd0;
            scratch_q <= 12'd0;
            cnt_q     <= 4'd0;
            pend_q    <= 1'b0;
            pbuf_q    <= 8'd0;
            ones_q    <= 4'd0;
            tens_q    <= 4'd0;
            hund_q    <= 4'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            pbuf_q    <= pbuf_d;
            ones_q    <= ones_d;
            tens_q    <= tens_d;
            hund_q    <= hund_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            valid_q   <= valid_d;
        end
    end

    // Display decode from the committed digits only.
    always_comb begin
        if (!valid_q) begin
            hex0_o = 8'b10111111;
            hex1_o = 8'b10111111;
            hex2_o = 8'b10111111;
        end else begin
            hex0_o = {1'b1, seg7(ones_q)};
            if (blank_zeros_i && (hund_q == 4'd0)) begin
                hex2_o = 8'hFF;
            end else begin
                hex2_o = {1'b1, seg7(hund_q)};
            end
            if (blank_zeros_i && (hund_q == 4'd0) && (tens_q == 4'd0)) begin
                hex1_o = 8'hFF;
            end else begin
                hex1_o = {1'b1, seg7(tens_q)};
            end
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign valid_o    = valid_q;
    assign ones_o     = ones_q;
    assign tens_o     = tens_q;
    assign hundreds_o = hund_q;

endmodule

// File: tb/tb_bcd_display_driver.sv
// Testbench for bcd_display_driver: a behavioural model (integer division for
// the digits, a countdown for latency, a single pending slot) is compared to
// the DUT on every falling edge, plus directed literal checks.
module tb_bcd_display_driver;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic [7:0] value_i;
    logic       load_i;
    logic       blank_zeros_i;
    logic       busy_o, done_o, valid_o;
    logic [3:0] ones_o, tens_o, hundreds_o;
    logic [7:0] hex0_o, hex1_o, hex2_o;

    bcd_display_driver dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .value_i       (value_i),
        .load_i        (load_i),
        .blank_zeros_i (blank_zeros_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .valid_o       (valid_o),
        .ones_o        (ones_o),
        .tens_o        (tens_o),
        .hundreds_o    (hundreds_o),
        .hex0_o        (hex0_o),
        .hex1_o        (hex1_o),
        .hex2_o        (hex2_o)
    );

    always #5 clk_i = ~clk_i;

    int n_vec     = 0;
    int n_err     = 0;
    int done_seen = 0;

    // Reference model state
    bit m_busy, m_pend, m_done, m_valid;
    int m_left, m_cur, m_pval, m_h, m_t, m_o;

    // Behavioural model: a request takes 8 edges, one pending slot, last load wins.
    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_busy = 0; m_pend = 0; m_done = 0; m_valid = 0;
            m_left = 0; m_cur = 0; m_pval = 0; m_h = 0; m_t = 0; m_o = 0;
        end else begin
            m_done = 0;
            if (m_busy) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_h = m_cur / 100;
                    m_t = (m_cur / 10) % 10;
                    m_o = m_cur % 10;
                    m_done = 1;
                    m_valid = 1;
                    m_busy = 0;
                end
                if (load_i) begin
                    m_pend = 1;
                    m_pval = value_i;
                end
            end else if (m_pend) begin
                m_busy = 1; m_left = 8; m_cur = m_pval;
                m_pend = 0;
                if (load_i) begin
                    m_pend = 1;
                    m_pval = value_i;
                end
            end else if (load_i) begin
                m_busy = 1; m_left = 8; m_cur = value_i;
            end
        end
    end

    function automatic logic [7:0] hexm(input int d, input bit blank);
        logic [6:0] s;
        if (!m_valid) return 8'b10111111;
        if (blank) return 8'hFF;
        case (d)
            0: s = 7'b1000000;
            1: s = 7'b1111001;
            2: s = 7'b0100100;
            3: s = 7'b0110000;
            4: s = 7'b0011001;
            5: s = 7'b0010010;
            6: s = 7'b0000010;
            7: s = 7'b1111000;
            8: s = 7'b0000000;
            9: s = 7'b0011000;
            default: s = 7'b0111111;
        endcase
        return {1'b1, s};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("busy",     32'(busy_o),     32'(m_busy));
        chk("done",     32'(done_o),     32'(m_done));
        chk("valid",    32'(valid_o),    32'(m_valid));
        chk("hundreds", 32'(hundreds_o), 32'(m_h));
        chk("tens",     32'(tens_o),     32'(m_t));
        chk("ones",     32'(ones_o),     32'(m_o));
        chk("hex0",     32'(hex0_o),     32'(hexm(m_o, 1'b0)));
        chk("hex1",     32'(hex1_o),     32'(hexm(m_t, blank_zeros_i && m_h == 0 && m_t == 0)));
        chk("hex2",     32'(hex2_o),     32'(hexm(m_h, blank_zeros_i && m_h == 0)));
        if (done_o === 1'b1) done_seen++;
    endtask

    task automatic step(input bit ld, input logic [7:0] v);
        load_i  = ld;
        value_i = v;
        @(posedge clk_i);
        @(negedge clk_i);
        compare_all();
    endtask

    int busy_cnt;
    int d0;

    initial begin
        rst_ni = 1'b0; load_i = 1'b0; value_i = 8'd0; blank_zeros_i = 1'b0;
        repeat (3) step(1'b0, 8'd0);
        rst_ni = 1'b1;

        // No load after reset: dashes, not valid
        repeat (10) step(1'b0, 8'd0);
        chk("idle_valid", 32'(valid_o), 32'd0);
        chk("idle_hex0", 32'(hex0_o), 32'h BF);
        chk("idle_hex1", 32'(hex1_o), 32'h BF);
        chk("idle_hex2", 32'(hex2_o), 32'h BF);

        // 120: eight busy cycles, then 1,2,0
        busy_cnt = 0;
        step(1'b1, 8'd120);
        if (busy_o === 1'b1) busy_cnt++;
        repeat (7) begin
            step(1'b0, 8'd0);
            if (busy_o === 1'b1) busy_cnt++;
        end
        chk("l120_busy_cycles", 32'(busy_cnt), 32'd8);
        step(1'b0, 8'd0);
        chk("l120_busy_end", 32'(busy_o), 32'd0);
        chk("l120_done", 32'(done_o), 32'd1);
        chk("l120_h", 32'(hundreds_o), 32'd1);
        chk("l120_t", 32'(tens_o), 32'd2);
        chk("l120_o", 32'(ones_o), 32'd0);
        chk("l120_hex2", 32'(hex2_o), 32'b11111001);
        chk("l120_hex1", 32'(hex1_o), 32'b10100100);
        chk("l120_hex0", 32'(hex0_o), 32'b11000000);
        step(1'b0, 8'd0);
        chk("l120_done_once", 32'(done_o), 32'd0);

        // 7 with and without blanking
        step(1'b1, 8'd7);
        repeat (8) step(1'b0, 8'd0);
        blank_zeros_i = 1'b1;
        #1;
        chk("l7_blank_hex2", 32'(hex2_o), 32'h FF);
        chk("l7_blank_hex1", 32'(hex1_o), 32'h FF);
        chk("l7_blank_hex0", 32'(hex0_o), 32'b11111000);
        blank_zeros_i = 1'b0;
        #1;
        chk("l7_hex2", 32'(hex2_o), 32'b11000000);
        chk("l7_hex1", 32'(hex1_o), 32'b11000000);

        // 200, then 45 at N+3, 99 at N+5: 45 overwritten
        step(1'b1, 8'd200);
        step(1'b0, 8'd0);
        step(1'b0, 8'd0);
        step(1'b1, 8'd45);
        step(1'b0, 8'd0);
        step(1'b1, 8'd99);
        step(1'b0, 8'd0);
        step(1'b0, 8'd0);
        step(1'b0, 8'd0);
        chk("pend_busy_gap", 32'(busy_o), 32'd0);
        chk("pend_200", {20'd0, hundreds_o, tens_o, ones_o}, 32'h200);
        repeat (8) begin
            step(1'b0, 8'd0);
            chk("pend_no45", 32'(tens_o == 4'd4 && ones_o == 4'd5), 32'd0);
        end
        step(1'b0, 8'd0);
        chk("pend_99_done", 32'(done_o), 32'd1);
        chk("pend_99", {20'd0, hundreds_o, tens_o, ones_o}, 32'h099);

        // Full sweep
        d0 = done_seen;
        for (int v = 0; v < 256; v++) begin
            step(1'b1, 8'(v));
            repeat (8) step(1'b0, 8'd0);
            chk("sweep_h", 32'(hundreds_o), 32'(v / 100));
            chk("sweep_t", 32'(tens_o), 32'((v / 10) % 10));
            chk("sweep_o", 32'(ones_o), 32'(v % 10));
        end
        chk("sweep_done_count", 32'(done_seen - d0), 32'd256);

        // Random traffic
        repeat (3000) begin
            blank_zeros_i = 1'($urandom_range(0, 1));
            step(($urandom_range(0, 4) == 0), 8'($urandom_range(0, 255)));
        end

        // Reset at N+4 of 255, with a pending request outstanding
        repeat (20) step(1'b0, 8'd0);
        step(1'b1, 8'd255);
        step(1'b0, 8'd0);
        step(1'b1, 8'd33);
        step(1'b0, 8'd0);
        step(1'b0, 8'd0);
        #1 rst_ni = 1'b0;
        #1;
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_digits", {20'd0, hundreds_o, tens_o, ones_o}, 32'h000);
        chk("rst_hex2", 32'(hex2_o), 32'h BF);
        chk("rst_hex0", 32'(hex0_o), 32'h BF);
        compare_all();
        step(1'b0, 8'd0);
        step(1'b0, 8'd0);
        rst_ni = 1'b1;
        d0 = done_seen;
        repeat (14) step(1'b0, 8'd0);
        chk("rst_no_done", 32'(done_seen - d0), 32'd0);
        chk("rst_still_invalid", 32'(valid_o), 32'd0);
        chk("rst_hex1_dash", 32'(hex1_o), 32'h BF);

        // First load after reset behaves normally
        step(1'b1, 8'd58);
        repeat (7) step(1'b0, 8'd0);
        chk("post_rst_busy", 32'(busy_o), 32'd1);
        step(1'b0, 8'd0);
        chk("post_rst_done", 32'(done_o), 32'd1);
        chk("post_rst_58", {20'd0, hundreds_o, tens_o, ones_o}, 32'h058);
        step(1'b0, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
